// File: rtl/mem_dump_uart_tx.sv
// Sweeps the RISC_V user data-memory debug port and streams each word as a
// 3-byte 8N1 UART frame: {2'b00,addr}, data[15:8], data[7:0].
module mem_dump_uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int SETTLE       = 2,
  parameter int FIRST_ADDR   = 0,
  parameter int LAST_ADDR    = 63
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] user_read,
  output logic [5:0]  user_in,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] CLK_LAST    = CW'(CLKS_PER_BIT - 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);
  localparam logic [5:0]    FIRST       = 6'(FIRST_ADDR);
  localparam logic [5:0]    LAST        = 6'(LAST_ADDR);
  localparam logic [4:0]    BIT_LAST    = 5'd29;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_SEND
  } state_t;

  state_t          r_state, w_state_next;
  logic [5:0]      r_addr, w_addr_next;
  logic            r_tx, w_tx_next;
  logic            r_busy, w_busy_next;
  logic            r_done, w_done_next;
  logic [28:0]     r_frame, w_frame_next;
  logic [SW-1:0]   r_settle, w_settle_next;
  logic [CW-1:0]   r_clk_cnt, w_clk_cnt_next;
  logic [4:0]      r_bit, w_bit_next;
  logic [29:0]     w_frame_load;

  // Whole frame, LSB first: three start/data/stop byte groups back to back.
  assign w_frame_load = {1'b1, user_read[7:0],  1'b0,
                         1'b1, user_read[15:8], 1'b0,
                         1'b1, 2'b00, r_addr,   1'b0};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_addr    <= FIRST;
      r_tx      <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_frame   <= '0;
      r_settle  <= '0;
      r_clk_cnt <= '0;
      r_bit     <= '0;
    end else begin
      r_state   <= w_state_next;
      r_addr    <= w_addr_next;
      r_tx      <= w_tx_next;
      r_busy    <= w_busy_next;
      r_done    <= w_done_next;
      r_frame   <= w_frame_next;
      r_settle  <= w_settle_next;
      r_clk_cnt <= w_clk_cnt_next;
      r_bit     <= w_bit_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_addr_next    = r_addr;
    w_tx_next      = r_tx;
    w_busy_next    = r_busy;
    w_done_next    = 1'b0;
    w_frame_next   = r_frame;
    w_settle_next  = r_settle;
    w_clk_cnt_next = r_clk_cnt;
    w_bit_next     = r_bit;
    unique case (r_state)
      S_IDLE: begin
        w_tx_next = 1'b1;
        if (start) begin
          w_state_next  = S_SETTLE;
          w_busy_next   = 1'b1;
          w_addr_next   = FIRST;
          w_settle_next = '0;
        end
      end
      S_SETTLE: begin
        if (r_settle == SETTLE_LAST) begin
          // Capture edge: the word is frozen here, and the start bit goes out at once.
          w_frame_next   = w_frame_load[29:1];
          w_tx_next      = w_frame_load[0];
          w_clk_cnt_next = '0;
          w_bit_next     = '0;
          w_state_next   = S_SEND;
        end else begin
          w_settle_next = r_settle + 1'b1;
        end
      end
      S_SEND: begin
        if (r_clk_cnt == CLK_LAST) begin
          w_clk_cnt_next = '0;
          if (r_bit == BIT_LAST) begin
            w_tx_next = 1'b1;
            if (r_addr == LAST) begin
              w_state_next = S_IDLE;
              w_busy_next  = 1'b0;
              w_done_next  = 1'b1;
              w_addr_next  = FIRST;
            end else begin
              w_state_next  = S_SETTLE;
              w_addr_next   = r_addr + 1'b1;
              w_settle_next = '0;
            end
          end else begin
            w_bit_next   = r_bit + 1'b1;
            w_tx_next    = r_frame[0];
            w_frame_next = {1'b1, r_frame[28:1]};
          end
        end else begin
          w_clk_cnt_next = r_clk_cnt + 1'b1;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  assign user_in = r_addr;
  assign tx      = r_tx;
  assign busy    = r_busy;
  assign done    = r_done;

endmodule

// File: tb/tb_mem_dump_uart_tx.sv
// Bench for mem_dump_uart_tx: a 0..3 sweep instance and a single-address (63) instance,
// with a UART decoder and a byte-list reference model.
module tb_mem_dump_uart_tx;

  localparam int CPB = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_a, start_b;
  logic [15:0] mem_a [0:63];
  logic [15:0] user_read_a, user_read_b;
  logic [5:0]  user_in_a, user_in_b;
  logic        tx_a, busy_a, done_a;
  logic        tx_b, busy_b, done_b;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int framing_err = 0;

  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];

  assign user_read_a = mem_a[user_in_a];
  assign user_read_b = (user_in_b == 6'd63) ? 16'h0F0F : 16'h1234;

  mem_dump_uart_tx #(.CLKS_PER_BIT(CPB), .SETTLE(2), .FIRST_ADDR(0), .LAST_ADDR(3)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .user_read(user_read_a),
    .user_in(user_in_a), .tx(tx_a), .busy(busy_a), .done(done_a)
  );

  mem_dump_uart_tx #(.CLKS_PER_BIT(CPB), .SETTLE(2), .FIRST_ADDR(63), .LAST_ADDR(63)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .user_read(user_read_b),
    .user_in(user_in_b), .tx(tx_b), .busy(busy_b), .done(done_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // UART decoder for dut_a: samples each bit in its middle, counted from the start-bit detect.
  bit         mon_active = 0;
  int         mon_cnt = 0;
  logic [7:0] mon_byte;
  always @(negedge clk) begin
    if (rst) begin
      mon_active = 0;
    end else if (!mon_active) begin
      if (tx_a === 1'b0) begin
        mon_active = 1;
        mon_cnt = 0;
      end
    end else begin
      mon_cnt++;
      if ((mon_cnt % CPB) == CPB / 2 && mon_cnt >= 6 && mon_cnt <= 34)
        mon_byte[(mon_cnt - 6) / CPB] = tx_a;
      if (mon_cnt == 38) begin
        if (tx_a !== 1'b1) framing_err++;
        rx_q.push_back(mon_byte);
        mon_active = 0;
      end
    end
  end

  task automatic build_expected(input int first, input int last);
    for (int a = first; a <= last; a++) begin
      exp_q.push_back({2'b00, 6'(a)});
      exp_q.push_back(mem_a[a][15:8]);
      exp_q.push_back(mem_a[a][7:0]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (tx_a !== 1'b1 || busy_a !== 1'b0 || done_a !== 1'b0 || user_in_a !== 6'd0) begin
      errors++;
      $display("FAIL reset_a: tx=%b busy=%b done=%b user_in=%0d, required 1 0 0 0", tx_a, busy_a, done_a, user_in_a);
    end
    checks++;
    if (tx_b !== 1'b1 || busy_b !== 1'b0 || done_b !== 1'b0 || user_in_b !== 6'd63) begin
      errors++;
      $display("FAIL reset_b: tx=%b busy=%b done=%b user_in=%0d, required 1 0 0 63", tx_b, busy_b, done_b, user_in_b);
    end
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (tx_a !== 1'b1 || busy_a !== 1'b0 || done_a !== 1'b0 || user_in_a !== 6'd0) begin
        errors++;
        $display("FAIL idle_a cycle %0d: tx=%b busy=%b done=%b user_in=%0d, required 1 0 0 0", i, tx_a, busy_a, done_a, user_in_a);
      end
    end
  endtask

  task automatic test_single_sweep();
    int k;
    for (int a = 0; a < 64; a++) mem_a[a] = 16'hA5C3 + 16'(a);
    rx_q.delete(); exp_q.delete();
    build_expected(0, 3);
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    checks++;
    if (busy_a !== 1'b1) begin errors++; $display("FAIL sweep_busy_rise: busy=%b, required 1", busy_a); end
    k = 0;
    while (done_a !== 1'b1 && k < 2000) begin @(negedge clk); k++; end
    checks++;
    if (k != 488) begin errors++; $display("FAIL sweep_done_time: done after %0d cycles, required 488", k); end
    checks++;
    if (busy_a !== 1'b0) begin errors++; $display("FAIL sweep_busy_fall: busy=%b in done cycle, required 0", busy_a); end
    @(negedge clk);
    checks++;
    if (done_a !== 1'b0 || user_in_a !== 6'd0) begin
      errors++;
      $display("FAIL sweep_after_done: done=%b user_in=%0d, required 0 0", done_a, user_in_a);
    end
    checks++;
    if (rx_q.size() != exp_q.size()) begin errors++; $display("FAIL sweep_byte_count: got %0d, required %0d", rx_q.size(), exp_q.size()); end
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL sweep_byte %0d: got %h, required %h", i, rx_q[i], exp_q[i]); end
    end
    checks++;
    if (framing_err != 0) begin errors++; $display("FAIL sweep_framing: %0d bad stop bits, required 0", framing_err); end
  endtask

  task automatic test_ignore_start();
    int pulse_at, done_cnt;
    for (int a = 0; a < 64; a++) mem_a[a] = 16'($urandom);
    rx_q.delete(); exp_q.delete();
    build_expected(0, 3);
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    pulse_at = -1; done_cnt = 0;
    for (int n = 1; n <= 800; n++) begin
      @(negedge clk);
      if (done_a === 1'b1) done_cnt++;
      if (user_in_a == 6'd1 && pulse_at < 0) pulse_at = n + int'($urandom_range(1, 100));
      start_a = (n == pulse_at);
    end
    start_a = 1'b0;
    checks++;
    if (done_cnt != 1) begin errors++; $display("FAIL ignore_done_count: got %0d, required 1", done_cnt); end
    checks++;
    if (busy_a !== 1'b0) begin errors++; $display("FAIL ignore_busy_end: busy=%b, required 0", busy_a); end
    checks++;
    if (rx_q.size() != exp_q.size()) begin errors++; $display("FAIL ignore_byte_count: got %0d, required %0d", rx_q.size(), exp_q.size()); end
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL ignore_byte %0d: got %h, required %h", i, rx_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_midframe();
    int bad;
    for (int a = 0; a < 64; a++) mem_a[a] = 16'hA5C3 + 16'(a);
    rx_q.delete(); exp_q.delete();
    build_expected(0, 3);
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    // Bit 5 of byte 1 of address 2: frame start 2+2*122, byte 1 +40, bit 5 +20, one cycle in.
    repeat (307) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (tx_a !== 1'b1 || busy_a !== 1'b0 || user_in_a !== 6'd0 || done_a !== 1'b0) begin
      errors++;
      $display("FAIL midreset_outputs: tx=%b busy=%b user_in=%0d done=%b, required 1 0 0 0", tx_a, busy_a, user_in_a, done_a);
    end
    checks++;
    if (rx_q.size() != 7) begin errors++; $display("FAIL midreset_byte_count: got %0d, required 7", rx_q.size()); end
    for (int i = 0; i < rx_q.size() && i < 7; i++) begin
      checks++;
      if (rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL midreset_byte %0d: got %h, required %h", i, rx_q[i], exp_q[i]); end
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (tx_a !== 1'b1 || busy_a !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL midreset_quiet: %0d cycles with tx low or busy, required 0", bad); end
  endtask

  task automatic test_back_to_back();
    int k, m;
    for (int a = 0; a < 64; a++) mem_a[a] = 16'hA5C3 + 16'(a);
    rx_q.delete(); exp_q.delete();
    build_expected(0, 3);
    build_expected(0, 3);
    @(negedge clk); start_a = 1'b1;
    @(negedge clk);
    k = 0;
    while (done_a !== 1'b1 && k < 2000) begin @(negedge clk); k++; end
    checks++;
    if (k != 488) begin errors++; $display("FAIL b2b_first_done: after %0d cycles, required 488", k); end
    @(negedge clk);
    m = 1;
    checks++;
    if (busy_a !== 1'b1 || done_a !== 1'b0) begin
      errors++;
      $display("FAIL b2b_restart: busy=%b done=%b, required 1 0", busy_a, done_a);
    end
    start_a = 1'b0;
    while (done_a !== 1'b1 && m < 2000) begin @(negedge clk); m++; end
    checks++;
    if (m != 489) begin errors++; $display("FAIL b2b_second_done: %0d cycles after first done, required 489", m); end
    repeat (5) @(negedge clk);
    checks++;
    if (busy_a !== 1'b0) begin errors++; $display("FAIL b2b_no_third: busy=%b, required 0", busy_a); end
    checks++;
    if (rx_q.size() != exp_q.size()) begin errors++; $display("FAIL b2b_byte_count: got %0d, required %0d", rx_q.size(), exp_q.size()); end
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_byte %0d: got %h, required %h", i, rx_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_single_frame();
    logic [7:0] exp_b [3];
    logic [7:0] d;
    int c0, w, stop_bad;
    exp_b[0] = 8'h3F; exp_b[1] = 8'h0F; exp_b[2] = 8'h0F;
    @(negedge clk);
    checks++;
    if (user_in_b !== 6'd63) begin errors++; $display("FAIL single_idle_addr: user_in=%0d, required 63", user_in_b); end
    start_b = 1'b1;
    @(negedge clk); start_b = 1'b0;
    c0 = cyc;
    stop_bad = 0;
    for (int j = 0; j < 3; j++) begin
      w = 0;
      while (tx_b !== 1'b0 && w < 300) begin @(negedge clk); w++; end
      repeat (CPB / 2) @(negedge clk);
      for (int b = 0; b < 8; b++) begin
        repeat (CPB) @(negedge clk);
        d[b] = tx_b;
      end
      repeat (CPB) @(negedge clk);
      if (tx_b !== 1'b1) stop_bad++;
      checks++;
      if (d !== exp_b[j]) begin errors++; $display("FAIL single_byte %0d: got %h, required %h", j, d, exp_b[j]); end
    end
    checks++;
    if (stop_bad != 0) begin errors++; $display("FAIL single_framing: %0d bad stop bits, required 0", stop_bad); end
    w = 0;
    while (done_b !== 1'b1 && w < 300) begin @(negedge clk); w++; end
    checks++;
    if (cyc - c0 != 122) begin errors++; $display("FAIL single_done_time: %0d cycles, required 122", cyc - c0); end
    checks++;
    if (busy_b !== 1'b0 || user_in_b !== 6'd63) begin
      errors++;
      $display("FAIL single_end: busy=%b user_in=%0d, required 0 63", busy_b, user_in_b);
    end
    repeat (50) @(negedge clk);
    checks++;
    if (busy_b !== 1'b0 || tx_b !== 1'b1) begin
      errors++;
      $display("FAIL single_one_frame: busy=%b tx=%b, required 0 1", busy_b, tx_b);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    for (int a = 0; a < 64; a++) mem_a[a] = 16'hA5C3 + 16'(a);
    test_reset();
    test_single_sweep();
    test_ignore_start();
    test_reset_midframe();
    test_back_to_back();
    test_single_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
